// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory sequencer with lane steering, load formatting and LL/SC link
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_half,
    input  logic        mem_byte,
    input  logic        mem_sign_ext,
    input  logic        llsc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_out,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        link_q, link_d;
    logic [29:0] link_addr_q, link_addr_d;
    logic        cancel_q, cancel_d;
    // Attributes of the in-flight access, captured at issue so the stage
    // inputs may change (e.g. after a flush) without corrupting completion.
    logic        op_rd_q, op_rd_d;
    logic        op_ll_q, op_ll_d;
    logic        op_sc_q, op_sc_d;
    logic        op_sign_q, op_sign_d;

    logic        access;
    logic        is_wr;
    logic        sc_fail_raw;
    logic        start;
    logic        sc_fail;
    logic        cancel_now;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    // Pick the lane indicated by the enables and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [3:0] be, input logic [31:0] d,
                                             input logic sx);
        logic [31:0] r;
        case (be)
            4'b1000: r = {{24{sx & d[31]}}, d[31:24]};
            4'b0100: r = {{24{sx & d[23]}}, d[23:16]};
            4'b0010: r = {{24{sx & d[15]}}, d[15:8]};
            4'b0001: r = {{24{sx & d[7]}},  d[7:0]};
            4'b1100: r = {{16{sx & d[31]}}, d[31:16]};
            4'b0011: r = {{16{sx & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Decode the requested access: alignment check, lane enables and store-data replication.
    always_comb begin
        access = mem_read | mem_write;
        is_wr  = mem_write & ~mem_read;
        if (mem_byte) begin
            addr_err = 1'b0;
            be_c     = 4'b1000 >> addr[1:0];
            wdata_c  = {4{wdata[7:0]}};
        end else if (mem_half) begin
            addr_err = access & addr[0];
            be_c     = addr[1] ? 4'b0011 : 4'b1100;
            wdata_c  = {2{wdata[15:0]}};
        end else begin
            addr_err = access & (addr[1:0] != 2'b00);
            be_c     = 4'b1111;
            wdata_c  = wdata;
        end
        sc_fail_raw = is_wr & llsc & (~link_q | (link_addr_q != addr[31:2]));
        start       = (state_q == S_IDLE) & access & ~addr_err & ~flush & ~sc_fail_raw;
        sc_fail     = (state_q == S_IDLE) & sc_fail_raw & ~addr_err & ~flush;
        cancel_now  = cancel_q | flush;
        stall_out   = start | sc_fail | (state_q == S_WAIT);
    end

    // Next-state and next-register logic for the IDLE/WAIT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        link_d      = link_q;
        link_addr_d = link_addr_q;
        cancel_d    = cancel_q;
        op_rd_d     = op_rd_q;
        op_ll_d     = op_ll_q;
        op_sc_d     = op_sc_q;
        op_sign_d   = op_sign_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_wr;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_c;
                    bus_wdata_d = wdata_c;
                    op_rd_d     = mem_read;
                    op_ll_d     = mem_read & llsc;
                    op_sc_d     = is_wr & llsc;
                    op_sign_d   = mem_sign_ext;
                    cancel_d    = 1'b0;
                end else if (sc_fail) begin
                    state_d = S_DONE;
                    rdata_d = 32'h0;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    cancel_d  = 1'b0;
                    if (!cancel_now) begin
                        if (op_rd_q) begin
                            rdata_d = fmt_load(bus_be_q, bus_rdata, op_sign_q);
                        end else if (op_sc_q) begin
                            rdata_d = 32'h1;
                        end
                        if (op_ll_q) begin
                            link_d      = 1'b1;
                            link_addr_d = bus_addr_q[31:2];
                        end
                    end
                    // Any completed store to the linked word breaks the reservation.
                    if (!op_rd_q && (op_sc_q || (bus_addr_q[31:2] == link_addr_q))) begin
                        link_d = 1'b0;
                    end
                    state_d = cancel_now ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (flush || !stall_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            link_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            link_q      <= 1'b0;
            link_addr_q <= 30'h0;
            cancel_q    <= 1'b0;
            op_rd_q     <= 1'b0;
            op_ll_q     <= 1'b0;
            op_sc_q     <= 1'b0;
            op_sign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            link_q      <= link_d;
            link_addr_q <= link_addr_d;
            cancel_q    <= cancel_d;
            op_rd_q     <= op_rd_d;
            op_ll_q     <= op_ll_d;
            op_sc_q     <= op_sc_d;
            op_sign_q   <= op_sign_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_half, mem_byte, mem_sign_ext, llsc;
    logic [31:0] addr, wdata;
    logic        stall_in, flush;
    logic        stall_out;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_last = 32'h0;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_half(mem_half),
        .mem_byte(mem_byte), .mem_sign_ext(mem_sign_ext), .llsc(llsc),
        .addr(addr), .wdata(wdata), .stall_in(stall_in), .flush(flush),
        .stall_out(stall_out), .rdata(rdata), .addr_err(addr_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; mem_half = 0; mem_byte = 0;
        mem_sign_ext = 0; llsc = 0; addr = 0; wdata = 0;
    endtask

    // One complete access: drive at a falling edge, count stall cycles, ack
    // on the ack_at-th WAIT cycle, then compare rdata against the scoreboard.
    task automatic access(input string tag, input logic rd, input logic wr, input logic half,
                          input logic byt, input logic sx, input logic ll,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] ack_data,
                          input logic exp_err, input logic exp_bus,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input int exp_stalls, input logic [31:0] exp_rdata,
                          input int hold_done);
        int cyc = 0;
        int waits = 0;
        int stalls = 0;
        logic done = 0;
        logic saw_req = 0;
        logic [31:0] e;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_half = half; mem_byte = byt;
        mem_sign_ext = sx; llsc = ll; addr = a; wdata = wd;
        #1;
        sb.push_back(exp_rdata);
        chk({tag, ".addr_err"}, {31'h0, addr_err}, {31'h0, exp_err});
        while (!done && cyc < 40) begin
            if (stall_out) begin
                stalls++;
                if (bus_req) begin
                    saw_req = 1;
                    waits++;
                    if (waits == 1) begin
                        chk({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
                        chk({tag, ".bus_be"}, {28'h0, bus_be}, {28'h0, exp_be});
                        chk({tag, ".bus_we"}, {31'h0, bus_we}, {31'h0, wr & ~rd});
                        chk({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
                    end
                    if (waits == ack_at) begin
                        bus_ack = 1;
                        bus_rdata = ack_data;
                    end
                end
                @(negedge clk);
                bus_ack = 0;
                bus_rdata = 32'h0;
                cyc++;
            end else begin
                done = 1;
            end
        end
        chk({tag, ".completed"}, {31'h0, done}, 32'h1);
        chk({tag, ".stall_cycles"}, stalls, exp_stalls);
        chk({tag, ".bus_cycle"}, {31'h0, saw_req}, {31'h0, exp_bus});
        e = sb.pop_front();
        chk({tag, ".rdata"}, rdata, e);
        exp_last = e;
        if (exp_stalls == 0) begin
            @(negedge clk);
            chk({tag, ".no_req"}, {31'h0, bus_req}, 32'h0);
            chk({tag, ".no_stall"}, {31'h0, stall_out}, 32'h0);
        end
        if (hold_done > 0) begin
            stall_in = 1;
            for (int i = 0; i < hold_done; i++) begin
                @(negedge clk);
                chk({tag, ".done_hold_req"}, {31'h0, bus_req}, 32'h0);
                chk({tag, ".done_hold_stall"}, {31'h0, stall_out}, 32'h0);
            end
            stall_in = 0;
        end
        chk({tag, ".req_low"}, {31'h0, bus_req}, 32'h0);
        idle_inputs();
    endtask

    initial begin
        rst_n = 0; stall_in = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset.bus_req", {31'h0, bus_req}, 32'h0);
        chk("reset.bus_we", {31'h0, bus_we}, 32'h0);
        chk("reset.bus_addr", bus_addr, 32'h0);
        chk("reset.bus_be", {28'h0, bus_be}, 32'h0);
        chk("reset.bus_wdata", bus_wdata, 32'h0);
        chk("reset.rdata", rdata, 32'h0);
        chk("reset.stall_out", {31'h0, stall_out}, 32'h0);
        rst_n = 1;

        //     tag         rd wr hf by sx ll addr        wdata        ack data          err bus be       wdata_exp     st rdata_exp     hold
        access("word_ld",  1, 0, 0, 0, 0, 0, 32'h100, 32'h0,        3, 32'h89ABCDEF, 0, 1, 4'b1111, 32'h0,        4, 32'h89ABCDEF, 0);
        access("byte_s1",  1, 0, 0, 1, 1, 0, 32'h101, 32'h0,        1, 32'h80FF7F01, 0, 1, 4'b0100, 32'h0,        2, 32'hFFFFFFFF, 0);
        access("byte_z3",  1, 0, 0, 1, 0, 0, 32'h103, 32'h0,        1, 32'h80FF7F01, 0, 1, 4'b0001, 32'h0,        2, 32'h00000001, 0);
        access("half_s2",  1, 0, 1, 0, 1, 0, 32'h102, 32'h0,        1, 32'h80FF7F01, 0, 1, 4'b0011, 32'h0,        2, 32'h00007F01, 0);
        access("half_s0",  1, 0, 1, 0, 1, 0, 32'h100, 32'h0,        2, 32'h80FF7F01, 0, 1, 4'b1100, 32'h0,        3, 32'hFFFF80FF, 3);
        access("byte_st",  0, 1, 0, 1, 0, 0, 32'h202, 32'h123456A5, 1, 32'h0,        0, 1, 4'b0010, 32'hA5A5A5A5, 2, 32'hFFFF80FF, 0);
        access("mis_half", 1, 0, 1, 0, 0, 0, 32'h101, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 32'h0,        0, 32'hFFFF80FF, 0);
        access("mis_word", 0, 1, 0, 0, 0, 0, 32'h102, 32'h77,       1, 32'h0,        1, 0, 4'b0000, 32'h0,        0, 32'hFFFF80FF, 0);
        access("ll_1",     1, 0, 0, 0, 0, 1, 32'h300, 32'h0,        1, 32'h12345678, 0, 1, 4'b1111, 32'h0,        2, 32'h12345678, 0);
        access("sc_ok",    0, 1, 0, 0, 0, 1, 32'h300, 32'h55,       1, 32'h0,        0, 1, 4'b1111, 32'h00000055, 2, 32'h00000001, 0);
        access("sc_again", 0, 1, 0, 0, 0, 1, 32'h300, 32'h66,       1, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00000000, 0);
        access("ll_2",     1, 0, 0, 0, 0, 1, 32'h300, 32'h0,        1, 32'hCAFEF00D, 0, 1, 4'b1111, 32'h0,        2, 32'hCAFEF00D, 0);
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        access("sc_flush", 0, 1, 0, 0, 0, 1, 32'h300, 32'h77,       1, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h00000000, 0);

        // Flush while the bus cycle is outstanding: data is discarded.
        @(negedge clk);
        mem_read = 1; addr = 32'h400; #1;
        chk("fl_wait.stall0", {31'h0, stall_out}, 32'h1);
        @(negedge clk);
        chk("fl_wait.req", {31'h0, bus_req}, 32'h1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("fl_wait.stall1", {31'h0, stall_out}, 32'h1);
        @(negedge clk);
        chk("fl_wait.stall2", {31'h0, stall_out}, 32'h1);
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_ack = 0; bus_rdata = 0;
        chk("fl_wait.req_drop", {31'h0, bus_req}, 32'h0);
        chk("fl_wait.back_idle", {31'h0, stall_out}, 32'h1);
        chk("fl_wait.rdata", rdata, exp_last);
        idle_inputs(); #1;
        chk("fl_wait.stall_off", {31'h0, stall_out}, 32'h0);

        // Reset during WAIT abandons the request at once.
        @(negedge clk);
        mem_read = 1; addr = 32'h500;
        @(negedge clk);
        chk("rst_wait.req", {31'h0, bus_req}, 32'h1);
        rst_n = 0; #1;
        chk("rst_wait.req_drop", {31'h0, bus_req}, 32'h0);
        chk("rst_wait.addr", bus_addr, 32'h0);
        chk("rst_wait.rdata", rdata, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
